autoanim_ctrl: RTL and testbench

//  Auto-animation controller in the LSPC video path. Owns the LSPCMODE speed byte and disable bit. Runs the
//  per-frame timer, advances the 3-bit animation frame counter, and substitutes the low tile-number bits of

---
 rtl/autoanim_ctrl_if.sv | 41 ++++
 rtl/autoanim_ctrl.sv | 160 ++++++++++++++++
 tb/tb_autoanim_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/autoanim_ctrl_if.sv
// -----------------------------------------------------------------------------
// autoanim_ctrl_if
//  Tile lookup path between the sprite map fetch and the tile fetch stage.
//  There are two streams:
//   request : tile_valid / tile_ready / tile_in / tile_attr  (upstream -> ctrl)
//   result  : tout_valid / tout_ready / tile_out             (ctrl -> downstream)
//  Modports:
//   slave  - the auto-animation controller
//   master - the surrounding fetch logic (or the testbench)
// -----------------------------------------------------------------------------
interface autoanim_ctrl_if #(
    parameter int TILE_W = 20
);
    logic              tile_valid;
    logic              tile_ready;
    logic [TILE_W-1:0] tile_in;
    logic [1:0]        tile_attr;
    logic              tout_valid;
    logic              tout_ready;
    logic [TILE_W-1:0] tile_out;

    modport slave (
        input  tile_valid,
        output tile_ready,
        input  tile_in,
        input  tile_attr,
        output tout_valid,
        input  tout_ready,
        output tile_out
    );

    modport master (
        output tile_valid,
        input  tile_ready,
        output tile_in,
        output tile_attr,
        input  tout_valid,
        output tout_ready,
        input  tile_out
    );
endinterface

// File: rtl/autoanim_ctrl.sv
// -----------------------------------------------------------------------------
// autoanim_ctrl
//  Auto-animation controller for the LSPC video path. It holds the LSPCMODE
//  speed byte and the auto-animation disable bit. It runs a per-frame down
//  timer that advances a 3-bit animation frame counter. It also replaces the
//  low tile-number bits of sprite fetches that are flagged for auto-animation.
//
//  Optional feature macro: AA_RESYNC_EN. When it is defined, the resync_i port
//  exists. A resync pulse restarts the counter and the timer.
//
//  Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   reg_wr_i     1-cycle LSPCMODE write strobe
//   din_i        write data: [15:8] = speed, [3] = auto-animation disable
//   frame_tick_i 1-cycle pulse once per frame (vblank start)
//   resync_i     (AA_RESYNC_EN only) counter/timer restart pulse
//   tile_if      request/result tile streams (slave side)
//   aa_count_o   current animation frame
//   aa_speed_o   speed register readback
//   aa_disable_o disable bit readback
// -----------------------------------------------------------------------------
module autoanim_ctrl #(
    parameter int         TILE_W      = 20,
    parameter logic [7:0] SPEED_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_wr_i,
    input  logic [15:0]          din_i,
    input  logic                 frame_tick_i,
`ifdef AA_RESYNC_EN
    input  logic                 resync_i,
`endif
    autoanim_ctrl_if.slave       tile_if,
    output logic [2:0]           aa_count_o,
    output logic [7:0]           aa_speed_o,
    output logic                 aa_disable_o
);

    logic [7:0]        speed_q,    speed_d;
    logic              disable_q,  disable_d;
    logic [7:0]        timer_q,    timer_d;
    logic [2:0]        count_q,    count_d;
    logic              tout_valid_q, tout_valid_d;
    logic [TILE_W-1:0] tile_out_q,   tile_out_d;
    logic              accept_s;
    logic              tile_ready_s;

    // LSPCMODE bits that this block does not own
    logic unused_din_s;
    assign unused_din_s = ^{din_i[7:4], din_i[2:0]};

    // Replace the low tile bits with the animation frame. An 8-frame
    // animation takes priority over a 4-frame one.
    function automatic logic [TILE_W-1:0] aa_sub(
        input logic [TILE_W-1:0] t,
        input logic [1:0]        attr,
        input logic [2:0]        cnt,
        input logic              dis
    );
        logic [TILE_W-1:0] r;
        r = t;
        if (dis) begin
            r = t;
        end else if (attr[1]) begin
            r = {t[TILE_W-1:3], cnt};
        end else if (attr[0]) begin
            r = {t[TILE_W-1:2], cnt[1:0]};
        end else begin
            r = t;
        end
        return r;
    endfunction

    // LSPCMODE write: speed and disable take the new value on the next edge
    always_comb begin
        speed_d   = speed_q;
        disable_d = disable_q;
        if (reg_wr_i) begin
            speed_d   = din_i[15:8];
            disable_d = din_i[3];
        end else begin
            speed_d   = speed_q;
            disable_d = disable_q;
        end
    end

    // Frame timer and animation counter. A reload always uses speed_q, so
    // a write in the same cycle only applies to the following reload.
    always_comb begin
        timer_d = timer_q;
        count_d = count_q;
`ifdef AA_RESYNC_EN
        if (resync_i) begin
            timer_d = speed_q;
            count_d = 3'd0;
        end else
`endif
        if (frame_tick_i) begin
            if (timer_q == 8'd0) begin
                timer_d = speed_q;
                count_d = count_q + 3'd1;
            end else begin
                timer_d = timer_q - 8'd1;
                count_d = count_q;
            end
        end else begin
            timer_d = timer_q;
            count_d = count_q;
        end
    end

    // The single output slot can accept a request when it is empty or is being drained
    assign tile_ready_s = ~tout_valid_q | tile_if.tout_ready;
    assign accept_s     = tile_if.tile_valid & tile_ready_s;

    // Output slot: load on accept, empty after handshake, otherwise hold
    always_comb begin
        tout_valid_d = tout_valid_q;
        tile_out_d   = tile_out_q;
        if (accept_s) begin
            tout_valid_d = 1'b1;
            tile_out_d   = aa_sub(tile_if.tile_in, tile_if.tile_attr, count_q, disable_q);
        end else if (tile_if.tout_ready) begin
            tout_valid_d = 1'b0;
            tile_out_d   = tile_out_q;
        end else begin
            tout_valid_d = tout_valid_q;
            tile_out_d   = tile_out_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q      <= SPEED_RESET;
            disable_q    <= 1'b0;
            timer_q      <= SPEED_RESET;
            count_q      <= 3'd0;
            tout_valid_q <= 1'b0;
            tile_out_q   <= '0;
        end else begin
            speed_q      <= speed_d;
            disable_q    <= disable_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            tout_valid_q <= tout_valid_d;
            tile_out_q   <= tile_out_d;
        end
    end

    assign tile_if.tile_ready = tile_ready_s;
    assign tile_if.tout_valid = tout_valid_q;
    assign tile_if.tile_out   = tile_out_q;
    assign aa_count_o         = count_q;
    assign aa_speed_o         = speed_q;
    assign aa_disable_o       = disable_q;

endmodule

// File: tb/tb_autoanim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_autoanim_ctrl
//  Directed bench for autoanim_ctrl. Inputs change on the falling edge and
//  outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_autoanim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr;
    logic [15:0] din;
    logic        frame_tick;
    logic        resync;
    logic [2:0]  aa_count;
    logic [7:0]  aa_speed;
    logic        aa_disable;

    int total = 0;
    int bad   = 0;

    autoanim_ctrl_if #(.TILE_W(20)) tif();

    autoanim_ctrl #(.TILE_W(20), .SPEED_RESET(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_wr_i     (reg_wr),
        .din_i        (din),
        .frame_tick_i (frame_tick),
`ifdef AA_RESYNC_EN
        .resync_i     (resync),
`endif
        .tile_if      (tif.slave),
        .aa_count_o   (aa_count),
        .aa_speed_o   (aa_speed),
        .aa_disable_o (aa_disable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d);
        @(negedge clk);
        reg_wr = 1'b1;
        din    = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic wr_tick(input logic [15:0] d);
        @(negedge clk);
        reg_wr     = 1'b1;
        din        = d;
        frame_tick = 1'b1;
        @(negedge clk);
        reg_wr     = 1'b0;
        frame_tick = 1'b0;
    endtask

    // One request/handshake with the downstream always ready
    task automatic send(input string tag, input logic [19:0] t, input logic [1:0] a,
                        input logic [19:0] exp);
        @(negedge clk);
        tif.tile_valid = 1'b1;
        tif.tile_in    = t;
        tif.tile_attr  = a;
        tif.tout_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, tif.tout_valid}, 32'd1);
        chk(tag, {12'd0, tif.tile_out}, {12'd0, exp});
        tif.tile_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        reg_wr         = 1'b0;
        din            = 16'h0000;
        frame_tick     = 1'b0;
        resync         = 1'b0;
        tif.tile_valid = 1'b0;
        tif.tile_in    = 20'h0;
        tif.tile_attr  = 2'b00;
        tif.tout_ready = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_count",  {29'd0, aa_count}, 32'd0);
        chk("rst_speed",  {24'd0, aa_speed}, 32'd0);
        chk("rst_dis",    {31'd0, aa_disable}, 32'd0);
        chk("rst_tvalid", {31'd0, tif.tout_valid}, 32'd0);
        chk("rst_tready", {31'd0, tif.tile_ready}, 32'd1);
        chk("rst_tout",   {12'd0, tif.tile_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Speed 0: one step per tick, and the counter wraps 7 -> 0
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("spd0_t%0d", k), {29'd0, aa_count}, k % 8);
        end

        // Speed 3 from reset (timer 0): steps on ticks 1, 5 and 9
        do_reset();
        wr(16'h0300);
        chk("spd3_speed", {24'd0, aa_speed}, 32'h03);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("spd3_t%0d", k), {29'd0, aa_count}, (k + 3) / 4);
        end

        // A write in the same cycle as a reloading tick: the reload still uses old speed 2
        do_reset();
        wr(16'h0200);
        wr_tick(16'h0500);
        chk("wrt_speed", {24'd0, aa_speed}, 32'h05);
        chk("wrt_c0",    {29'd0, aa_count}, 32'd1);
        tick();
        tick();
        chk("wrt_c2",    {29'd0, aa_count}, 32'd1);
        tick();
        chk("wrt_c3",    {29'd0, aa_count}, 32'd2);
        for (int k = 0; k < 5; k++) tick();
        chk("wrt_c8",    {29'd0, aa_count}, 32'd2);
        tick();
        chk("wrt_c9",    {29'd0, aa_count}, 32'd3);

        // Substitution with AA_COUNT = 5
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        chk("sub_count", {29'd0, aa_count}, 32'd5);
        send("sub_a10",   20'h12345, 2'b10, 20'h12345);
        send("sub_a01",   20'h12345, 2'b01, 20'h12345);
        send("sub_a00",   20'h12345, 2'b00, 20'h12345);
        send("sub_a10_0", 20'h12340, 2'b10, 20'h12345);
        send("sub_a01_0", 20'h12340, 2'b01, 20'h12341);
        send("sub_a11_f", 20'h1234F, 2'b11, 20'h1234D);
        send("sub_a01_f", 20'h1234F, 2'b01, 20'h1234D);
        send("sub_a00_f", 20'h1234F, 2'b00, 20'h1234F);
        wr(16'h0008);
        chk("dis_bit", {31'd0, aa_disable}, 32'd1);
        send("sub_dis", 20'h12340, 2'b10, 20'h12340);
        tick();
        chk("dis_count_runs", {29'd0, aa_count}, 32'd6);
        wr(16'h0000);
        chk("dis_clear", {31'd0, aa_disable}, 32'd0);
        do_reset();
        for (int k = 0; k < 5; k++) tick();

        // Stall for 4 cycles, then back-to-back transfers
        @(negedge clk);
        tif.tout_ready = 1'b0;
        tif.tile_valid = 1'b1;
        tif.tile_in    = 20'h12340;
        tif.tile_attr  = 2'b10;
        @(negedge clk);
        chk("stl_valid", {31'd0, tif.tout_valid}, 32'd1);
        chk("stl_outA",  {12'd0, tif.tile_out}, 32'h12345);
        tif.tile_in   = 20'hABCDE;
        tif.tile_attr = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            chk($sformatf("stl_ready%0d", k), {31'd0, tif.tile_ready}, 32'd0);
            chk($sformatf("stl_hold%0d", k),  {12'd0, tif.tile_out}, 32'h12345);
        end
        chk("stl_count", {29'd0, aa_count}, 32'd6);
        tif.tout_ready = 1'b1;
        #1;
        chk("rel_ready", {31'd0, tif.tile_ready}, 32'd1);
        @(negedge clk);
        chk("rel_validB", {31'd0, tif.tout_valid}, 32'd1);
        chk("rel_outB",   {12'd0, tif.tile_out}, 32'hABCDE);
        tif.tile_in = 20'h55555;
        @(negedge clk);
        chk("rel_validC", {31'd0, tif.tout_valid}, 32'd1);
        chk("rel_outC",   {12'd0, tif.tile_out}, 32'h55555);
        tif.tile_valid = 1'b0;
        @(negedge clk);
        chk("rel_empty",  {31'd0, tif.tout_valid}, 32'd0);

        // Reset in the middle of a stall with AA_COUNT = 6
        @(negedge clk);
        tif.tout_ready = 1'b0;
        tif.tile_valid = 1'b1;
        tif.tile_in    = 20'h12340;
        tif.tile_attr  = 2'b10;
        @(negedge clk);
        chk("mr_outpre", {12'd0, tif.tile_out}, 32'h12346);
        wr(16'h7F08);
        rst = 1'b1;
        #1;
        chk("mr_count",  {29'd0, aa_count}, 32'd0);
        chk("mr_speed",  {24'd0, aa_speed}, 32'd0);
        chk("mr_dis",    {31'd0, aa_disable}, 32'd0);
        chk("mr_tvalid", {31'd0, tif.tout_valid}, 32'd0);
        chk("mr_tout",   {12'd0, tif.tile_out}, 32'd0);
        chk("mr_tready", {31'd0, tif.tile_ready}, 32'd1);
        tif.tile_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

`ifdef AA_RESYNC_EN
        // A resync takes priority over a same-cycle tick and reloads with the old speed
        wr(16'h0300);
        tick();
        tick();
        chk("rs_pre", {29'd0, aa_count}, 32'd1);
        @(negedge clk);
        resync     = 1'b1;
        frame_tick = 1'b1;
        reg_wr     = 1'b1;
        din        = 16'h0700;
        @(negedge clk);
        resync     = 1'b0;
        frame_tick = 1'b0;
        reg_wr     = 1'b0;
        chk("rs_count", {29'd0, aa_count}, 32'd0);
        chk("rs_speed", {24'd0, aa_speed}, 32'h07);
        for (int k = 0; k < 3; k++) tick();
        chk("rs_c3", {29'd0, aa_count}, 32'd0);
        tick();
        chk("rs_c4", {29'd0, aa_count}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
